// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one external ALU between two requesters. A single transaction is
//   in flight at a time: IDLE grants one requester, EXEC gives the ALU one
//   cycle with the latched operands, and RESP holds the captured result until
//   the owning requester takes it. When both request at once, a round-robin
//   pointer picks the winner and then flips to the other port after each
//   completed response.
// Ports
//   clk, reset                : clock, synchronous active-high reset
//   reqN_valid/ready          : request handshake, N = 0/1
//   reqN_sel, reqN_a, reqN_b  : opcode and operands
//   rspN_valid/ready          : response handshake
//   rspN_result, rspN_zero    : captured result and branch flag
//   alu_sel, alu_a, alu_b     : drive the shared ALU (from latched registers)
//   alu_out, alu_zero         : shared ALU results
//   busy                      : high whenever a transaction is in flight
//   done_count                : completed-transaction counter (wraps)
module alu_arbiter #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [SEL_W-1:0]  req1_sel,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  output logic [SEL_W-1:0]  alu_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  output logic              busy,
  output logic [15:0]       done_count
);

  localparam logic [SEL_W-1:0] OP_DIV = SEL_W'(4'h3);
  localparam logic [SEL_W-1:0] OP_BEQ = SEL_W'(4'hE);
  localparam logic [SEL_W-1:0] OP_BNE = SEL_W'(4'hF);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t            state;
  logic              rr;
  logic              owner;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] result_q;
  logic              zero_q;

  logic any_valid;
  logic grant;
  logic rsp_take;

  // Grant selection: a lone requester wins outright, a tie goes to rr.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant = rr;
    end else if (req1_valid) begin
      grant = 1'b1;
    end else begin
      grant = 1'b0;
    end
  end

  // Readys are only offered in IDLE and only to the granted port, so at most
  // one handshake can occur and it always coincides with any_valid.
  assign req0_ready = (state == IDLE) && any_valid && !grant;
  assign req1_ready = (state == IDLE) && any_valid &&  grant;
  assign rsp_take   = owner ? rsp1_ready : rsp0_ready;

  assign alu_sel     = sel_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign rsp0_result = result_q;
  assign rsp1_result = result_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_zero   = zero_q;

  // Transaction FSM with registered busy/valid outputs and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr         <= 1'b0;
      owner      <= 1'b0;
      sel_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      done_count <= 16'd0;
      busy       <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            owner <= grant;
            sel_q <= grant ? req1_sel : req0_sel;
            a_q   <= grant ? req1_a   : req0_a;
            b_q   <= grant ? req1_b   : req0_b;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          // Division by zero never trusts the ALU: all-ones, flag clear.
          if ((sel_q == OP_DIV) && (b_q == '0)) begin
            result_q <= '1;
            zero_q   <= 1'b0;
          end else begin
            result_q <= alu_out;
            zero_q   <= ((sel_q == OP_BEQ) || (sel_q == OP_BNE)) ? alu_zero : 1'b0;
          end
          rsp0_valid <= ~owner;
          rsp1_valid <= owner;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_take) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
            rr         <= ~owner;
            done_count <= done_count + 16'd1;
            state      <= IDLE;
          end
        end
        default: begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_sel, req1_sel;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [15:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero;
  logic [3:0]  alu_sel;
  logic [15:0] alu_a, alu_b, alu_out;
  logic        alu_zero;
  logic        busy;
  logic [15:0] done_count;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .busy(busy), .done_count(done_count)
  );

  // Shared 16-bit ALU: {zero, out}. Divide by zero returns junk on purpose.
  function automatic logic [16:0] alu_fn(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] o;
    logic        z;
    case (s)
      4'h0: o = a + b;
      4'h1: o = a - b;
      4'h2: o = a * b;
      4'h3: o = (b == 16'd0) ? 16'hDEAD : a / b;
      4'h4: o = a & b;
      4'h5: o = a | b;
      4'h6: o = a ^ b;
      4'h7: o = ~a;
      4'h8: o = a << b[3:0];
      4'h9: o = a >> b[3:0];
      4'hE: o = {15'd0, a == b};
      4'hF: o = {15'd0, a != b};
      default: o = a;
    endcase
    if (s == 4'hE)      z = (a == b);
    else if (s == 4'hF) z = (a != b);
    else                z = (o == 16'd0);
    return {z, o};
  endfunction

  assign {alu_zero, alu_out} = alu_fn(alu_sel, alu_a, alu_b);

  // What the requester must receive: guard, then branch-only flag.
  function automatic logic [16:0] expect_rsp(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] r;
    if (s == 4'h3 && b == 16'd0) return {1'b0, 16'hFFFF};
    r = alu_fn(s, a, b);
    if (s != 4'hE && s != 4'hF) r[16] = 1'b0;
    return r;
  endfunction

  function automatic logic pick(input logic v0, input logic v1, input logic rr);
    return (v0 && v1) ? rr : v1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one job in flight, its age, its owner.
  bit          m_busy, m_resp, m_owner, m_rr;
  bit   [15:0] m_cnt;
  logic [3:0]  m_sel;
  logic [15:0] m_a, m_b;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0; m_resp <= 1'b0; m_owner <= 1'b0; m_rr <= 1'b0;
      m_cnt <= 16'd0; m_sel <= 4'd0; m_a <= 16'd0; m_b <= 16'd0;
    end else if (!m_busy) begin
      if (req0_valid || req1_valid) begin
        m_owner <= pick(req0_valid, req1_valid, m_rr);
        m_sel   <= pick(req0_valid, req1_valid, m_rr) ? req1_sel : req0_sel;
        m_a     <= pick(req0_valid, req1_valid, m_rr) ? req1_a   : req0_a;
        m_b     <= pick(req0_valid, req1_valid, m_rr) ? req1_b   : req0_b;
        m_busy  <= 1'b1;
        m_resp  <= 1'b0;
      end
    end else if (!m_resp) begin
      m_resp <= 1'b1;
    end else if (m_owner ? rsp1_ready : rsp0_ready) begin
      m_busy <= 1'b0;
      m_resp <= 1'b0;
      m_rr   <= ~m_owner;
      m_cnt  <= m_cnt + 16'd1;
    end
  end

  // Every-cycle comparison against the reference, away from the clock edge.
  always @(negedge clk) begin
    logic        g, e0, e1;
    logic [16:0] er;
    g  = pick(req0_valid, req1_valid, m_rr);
    e0 = !m_busy && (req0_valid || req1_valid) && !g;
    e1 = !m_busy && (req0_valid || req1_valid) &&  g;
    chk("m_req0_ready", {31'd0, req0_ready}, {31'd0, e0});
    chk("m_req1_ready", {31'd0, req1_ready}, {31'd0, e1});
    chk("m_busy", {31'd0, busy}, {31'd0, m_busy});
    chk("m_rsp0_valid", {31'd0, rsp0_valid}, {31'd0, m_resp && !m_owner});
    chk("m_rsp1_valid", {31'd0, rsp1_valid}, {31'd0, m_resp &&  m_owner});
    chk("m_done_count", {16'd0, done_count}, {16'd0, m_cnt});
    chk("m_alu_drive", {alu_sel, alu_a, alu_b[11:0]}, {m_sel, m_a, m_b[11:0]});
    if (m_resp) begin
      er = expect_rsp(m_sel, m_a, m_b);
      if (m_owner) chk("m_rsp1_data", {15'd0, rsp1_zero, rsp1_result}, {15'd0, er});
      else         chk("m_rsp0_data", {15'd0, rsp0_zero, rsp0_result}, {15'd0, er});
    end
  end

  task automatic wait_rsp(input bit p);
    bit seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      seen = p ? rsp1_valid : rsp0_valid;
    end
    chk(p ? "wait_rsp1" : "wait_rsp0", {31'd0, seen}, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int          ng;
    logic [1:0]  gseq [6];
    logic [1:0]  gexp [6];
    gexp = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_sel = 4'd0; req1_sel = 4'd0;
    req0_a = 16'd0; req0_b = 16'd0; req1_a = 16'd0; req1_b = 16'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", {16'd0, done_count}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);

    // Single ADD on port 0.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_sel = 4'h0; req0_a = 16'h000C; req0_b = 16'h000B; rsp0_ready = 1'b1;
    @(negedge clk);
    chk("add_ready", {30'd0, req0_ready, req1_ready}, 32'd2);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    chk("add_exec", {30'd0, busy, rsp0_valid}, 32'd2);
    @(negedge clk);
    chk("add_rsp", {14'd0, rsp0_valid, rsp0_zero, rsp0_result}, {14'd0, 2'b10, 16'h0017});
    @(negedge clk);
    chk("add_count", {16'd0, done_count}, 32'd1);

    // Simultaneous requests after reset: port 0 first.
    do_reset();
    req0_valid = 1'b1; req0_sel = 4'h1; req0_a = 16'h000C; req0_b = 16'h000B;
    req1_valid = 1'b1; req1_sel = 4'h2; req1_a = 16'h000C; req1_b = 16'h000B;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(negedge clk);
    chk("dual_grant0", {30'd0, req0_ready, req1_ready}, 32'd2);
    @(posedge clk); #1 req0_valid = 1'b0;
    wait_rsp(1'b0);
    chk("sub_result", {16'd0, rsp0_result}, 32'h0001);
    @(negedge clk);
    chk("dual_grant1", {30'd0, req0_ready, req1_ready}, 32'd1);
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_rsp(1'b1);
    chk("mul_result", {16'd0, rsp1_result}, 32'h0084);
    @(negedge clk);
    chk("dual_count", {16'd0, done_count}, 32'd2);

    // BEQ held by back-pressure while port 0 waits.
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_sel = 4'hE; req1_a = 16'h0005; req1_b = 16'h0005; rsp1_ready = 1'b0;
    @(negedge clk);
    chk("beq_grant", {30'd0, req0_ready, req1_ready}, 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_sel = 4'h3; req0_a = 16'h000C; req0_b = 16'h0000;
    wait_rsp(1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("beq_hold", {12'd0, rsp1_valid, rsp1_zero, busy, req0_ready, req1_ready, rsp1_result[10:0]},
                      {12'd0, 5'b11100, 11'd1});
      @(negedge clk);
    end
    @(posedge clk); #1 rsp1_ready = 1'b1;
    @(negedge clk);
    chk("beq_still", {31'd0, rsp1_valid}, 32'd1);
    @(negedge clk);
    chk("beq_done", {15'd0, rsp1_valid, done_count}, {16'd0, 16'd3});
    chk("div_grant", {30'd0, req0_ready, req1_ready}, 32'd2);
    @(posedge clk); #1 req0_valid = 1'b0;
    wait_rsp(1'b0);
    chk("div0_result", {15'd0, rsp0_zero, rsp0_result}, {15'd0, 1'b0, 16'hFFFF});

    // Reset while a response is pending, then fairness from rr=0.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_sel = 4'h0; req0_a = 16'h0001; req0_b = 16'h0002; rsp0_ready = 1'b0;
    @(posedge clk); #1 req0_valid = 1'b0;
    wait_rsp(1'b0);
    do_reset();
    @(negedge clk);
    chk("rst_resp", {12'd0, rsp0_valid, rsp1_valid, busy, done_count[12:0]}, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_sel = 4'h6; req1_sel = 4'h5;
    @(negedge clk);
    ng = 0;
    for (int k = 0; k < 6; k++) gseq[k] = 2'd3;
    for (int c = 0; c < 60 && ng < 6; c++) begin
      if (req0_ready || req1_ready) begin
        gseq[ng] = {1'b0, req1_ready};
        ng++;
      end
      if (ng < 6) @(negedge clk);
    end
    chk("fair_count", ng, 32'd6);
    for (int k = 0; k < 6; k++) chk("fair_order", {30'd0, gseq[k]}, {30'd0, gexp[k]});
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(posedge clk);

    // Randomized traffic; the every-cycle compare does the checking.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      reset      = ($urandom_range(0, 249) == 0);
      req0_valid = $urandom_range(0, 1) == 1;
      req1_valid = $urandom_range(0, 1) == 1;
      rsp0_ready = $urandom_range(0, 2) != 0;
      rsp1_ready = $urandom_range(0, 2) != 0;
      req0_sel = 4'($urandom); req1_sel = 4'($urandom);
      req0_a = 16'($urandom);  req1_a = 16'($urandom);
      case ($urandom_range(0, 3))
        0: begin req0_b = 16'd0; req1_b = 16'd0; end
        1: begin req0_b = req0_a; req1_b = req1_a; end
        default: begin req0_b = 16'($urandom); req1_b = 16'($urandom_range(0, 15)); end
      endcase
    end
    @(posedge clk); #1 reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
